mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store bus sequencer between EX/MEM and the data memory port.
// One access at a time, freezing the front of the pipeline until the bus phase completes.
module mem_access_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_in,
    input  logic        store_enable_in,
    input  logic [1:0]  mem_size_in,
    input  logic        is_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        mem_stall,
    output logic        misalign_out,
    output logic        bus_err_out
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, bus_err_q;
    logic [7:0]  cnt;

    logic        access, misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, fmt;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign access = mem_to_reg_in | store_enable_in;

    always_comb begin
        misaligned = 1'b0;
        case (mem_size_in)
            2'b01:   misaligned = addr_in[0];
            2'b10:   misaligned = (addr_in[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = store_data_in;
        case (mem_size_in)
            2'b00: begin
                be_n    = 4'b0001 << addr_in[1:0];
                wdata_n = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << {addr_in[1], 1'b0};
                wdata_n = {2{store_data_in[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data_in;
            end
        endcase
    end

    // Lane selection uses the latched address, not addr_in, which may have moved on.
    always_comb begin
        lane_b = dmem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            2'd3:    lane_b = dmem_rdata[31:24];
            default: lane_b = dmem_rdata[7:0];
        endcase
        lane_h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   fmt = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   fmt = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            load_data_out <= 32'd0;
            bus_err_q     <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            be_q          <= 4'd0;
            size_q        <= 2'd0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        addr_q  <= addr_in;
                        we_q    <= store_enable_in;
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        size_q  <= mem_size_in;
                        uns_q   <= is_unsigned_in;
                        cnt     <= 8'd0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        cnt   <= 8'd0;
                        state <= we_q ? DONE : RESP;
                    end else if (cnt == LAST) begin
                        bus_err_q <= 1'b1;
                        if (!we_q)
                            load_data_out <= 32'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        load_data_out <= fmt;
                        state         <= DONE;
                    end else if (cnt == LAST) begin
                        bus_err_q     <= 1'b1;
                        load_data_out <= 32'd0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces every bus and pipeline-control output low in the same cycle.
    assign dmem_req     = !rst && (state == REQ);
    assign dmem_we      = !rst && we_q;
    assign dmem_addr    = rst ? 32'd0 : {addr_q[31:2], 2'b00};
    assign dmem_be      = rst ? 4'd0  : be_q;
    assign dmem_wdata   = rst ? 32'd0 : wdata_q;
    assign bus_err_out  = !rst && bus_err_q;
    assign misalign_out = !rst && (state == IDLE) && access && misaligned;
    assign mem_stall    = !rst && (((state == IDLE) && access && !misaligned)
                                   || (state == REQ) || (state == RESP));

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model of the bus
// handshake, byte-lane rules and load formatting.
module tb_mem_access_unit;
    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_to_reg_in, store_enable_in, is_unsigned_in;
    logic [1:0]  mem_size_in;
    logic [31:0] addr_in, store_data_in;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data_out;
    logic [3:0]  dmem_be;
    logic        mem_stall, misalign_out, bus_err_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ld = 32'd0;

    mem_access_unit #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .mem_to_reg_in(mem_to_reg_in), .store_enable_in(store_enable_in),
        .mem_size_in(mem_size_in), .is_unsigned_in(is_unsigned_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .load_data_out(load_data_out), .mem_stall(mem_stall),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        mem_to_reg_in   = 1'b0;
        store_enable_in = 1'b0;
        mem_size_in     = 2'($urandom);
        is_unsigned_in  = 1'($urandom);
        addr_in         = $urandom;
        store_data_in   = $urandom;
    endtask

    // One access from IDLE to the next IDLE. gd/rd: cycles of bus latency before
    // gnt/rvalid; a value >= MAXW means the bus never answers.
    task automatic run(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gd, input int rd, input logic [31:0] rdat);
        logic        mis, we, done, to;
        logic [3:0]  be;
        logic [31:0] ea, ew, el;
        logic [7:0]  b;
        logic [15:0] h;
        we  = st;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        ea  = a & 32'hFFFF_FFFC;
        b   = 8'(rdat >> (8 * int'(a[1:0])));
        h   = 16'(rdat >> (16 * int'(a[1])));
        case (sz)
            2'd0: begin
                be = 4'(1 << int'(a[1:0]));
                ew = 32'(wd[7:0]) * 32'h0101_0101;
                el = uns ? 32'(b) : 32'($signed(b));
            end
            2'd1: begin
                be = 4'(3 << (2 * int'(a[1])));
                ew = 32'(wd[15:0]) * 32'h0001_0001;
                el = uns ? 32'(h) : 32'($signed(h));
            end
            default: begin
                be = 4'hF;
                ew = wd;
                el = rdat;
            end
        endcase

        mem_to_reg_in = ld; store_enable_in = st; mem_size_in = sz;
        is_unsigned_in = uns; addr_in = a; store_data_in = wd;
        #1;
        chk("misalign", 32'(misalign_out), 32'(mis));
        chk("stall_idle", 32'(mem_stall), 32'(!mis));
        chk("req_idle", 32'(dmem_req), 32'd0);
        @(negedge clk);
        clear_in();
        if (mis) begin
            #1;
            chk("req_mis", 32'(dmem_req), 32'd0);
            chk("stall_mis", 32'(mem_stall), 32'd0);
            chk("ld_mis", load_data_out, exp_ld);
            return;
        end

        done = 1'b0;
        for (int c = 0; c < MAXW && !done; c++) begin
            #1;
            chk("req", 32'(dmem_req), 32'd1);
            chk("stall_req", 32'(mem_stall), 32'd1);
            chk("addr", dmem_addr, ea);
            chk("be", 32'(dmem_be), 32'(be));
            chk("wdata", dmem_wdata, ew);
            chk("we", 32'(dmem_we), 32'(we));
            dmem_gnt    = (c == gd);
            dmem_rvalid = 1'($urandom);
            dmem_rdata  = $urandom;
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (c == gd) done = 1'b1;
        end
        to = !done;

        if (done && !we) begin
            done = 1'b0;
            for (int c = 0; c < MAXW && !done; c++) begin
                #1;
                chk("req_resp", 32'(dmem_req), 32'd0);
                chk("stall_resp", 32'(mem_stall), 32'd1);
                chk("ld_wait", load_data_out, exp_ld);
                dmem_rvalid = (c == rd);
                dmem_rdata  = (c == rd) ? rdat : $urandom;
                dmem_gnt    = 1'($urandom);
                @(negedge clk);
                dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
                if (c == rd) begin
                    done   = 1'b1;
                    exp_ld = el;
                end
            end
            to = !done;
        end
        if (to && !we) exp_ld = 32'd0;

        #1;
        chk("stall_done", 32'(mem_stall), 32'd0);
        chk("req_done", 32'(dmem_req), 32'd0);
        chk("bus_err", 32'(bus_err_out), 32'(to));
        chk("ld_done", load_data_out, exp_ld);
        @(negedge clk);
        #1;
        chk("bus_err_pulse", 32'(bus_err_out), 32'd0);
        chk("stall_after", 32'(mem_stall), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ld, st, uns;
        logic [1:0] sz;
        logic [31:0] a;
        int         gd, rd, kind;

        rst = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        clear_in();
        mem_to_reg_in = 1'b1; mem_size_in = 2'd3;
        repeat (3) @(negedge clk);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_mis", 32'(misalign_out), 32'd0);
        chk("rst_err", 32'(bus_err_out), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ld", load_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        clear_in();
        @(negedge clk);

        run(1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 0, 0, 32'd0);
        run(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'd0, 1, 2, 32'h8001_1234);
        chk("ld_shalf", load_data_out, 32'hFFFF_8001);
        run(1'b1, 1'b0, 2'd0, 1'b1, 32'h2001, 32'd0, 0, 0, 32'h1234_80FF);
        chk("ld_ubyte", load_data_out, 32'h0000_0080);
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h2002, 32'd0, 0, 0, 32'd0);
        chk("ld_after_mis", load_data_out, 32'h0000_0080);
        run(1'b1, 1'b1, 2'd2, 1'b0, 32'h3000, 32'hDEAD_BEEF, 2, 0, 32'd0);
        chk("ld_after_both", load_data_out, 32'h0000_0080);
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 99, 0, 32'd0);
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 0, 1, 32'hCAFE_F00D);

        // Reset while waiting for read data; a late rvalid must be dropped.
        mem_to_reg_in = 1'b1; mem_size_in = 2'd2; addr_in = 32'h4000;
        @(negedge clk);
        clear_in(); dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("resp_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_resp_stall", 32'(mem_stall), 32'd0);
        chk("rst_resp_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ld = 32'd0;
        #1;
        chk("rst_resp_ld", load_data_out, exp_ld);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("late_rvalid_ld", load_data_out, exp_ld);
        chk("late_rvalid_req", 32'(dmem_req), 32'd0);
        chk("late_rvalid_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            kind = $urandom_range(0, 2);
            ld   = (kind != 1);
            st   = (kind != 0);
            gd   = (ld && !st && $urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
            rd   = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
            run(ld, st, sz, uns, a, $urandom, gd, rd, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
